dnoc_itf_dma_wr: RTL
====================

Name: dnoc_itf_dma_wr

Overview:
- NoC-to-L2 DMA write engine; the receive-side counterpart of the DMA read engine in dnoc_itf.
- Accepts a write command from the NoC config path and receives 256-bit data beats from the NoC input.
- Writes the beats into L2 dmem through a 4-level loop address generator, with optional ping/pong buffering gated by consumer buffer state.
- Returns one write response per burst to the NoC.

Parameters:
- DW, 256, data beat width.
- AW, 13, L2 dmem word address width.
- PPW, 11, pingpong pair-count width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- n_cfg_d_w_ram_base_addr  in  2xAW  [0]=ping base, [1]=pong base.
- n_cfg_d_w_ping_lenth  in  AW  ping beats minus 1.
- n_cfg_d_w_pong_lenth  in  AW  pong beats minus 1.
- n_cfg_d_w_pingpong_en  in  1  alternate ping/pong; 0 = single ping burst.
- n_cfg_d_w_pingpong_num  in  PPW  ping+pong pairs to receive.
- n_cfg_d_w_loop_lenth  in  4xAW  per-level iteration count minus 1.
- n_cfg_d_w_loop_gap  in  4xAW  per-level address increment.
- noc_cmd_dma_wr_req  in  1  start request.
- noc_cmd_dma_wr_gnt  out  1  one-cycle accept.
- pingpong_state  in  2  [0]=ping buffer free, [1]=pong buffer free.
- pingpong_wr_done  out  1  pulse per completed buffer (pingpong_en only).
- d_w_transaction_done  out  1  pulse at end of command.
- noc_in_dma_wr_data  in  DW  beat data.
- noc_in_dma_wr_valid  in  1  beat valid.
- noc_in_dma_wr_last  in  1  sender's last-beat marker.
- noc_in_dma_wr_ready  out  1  beat ready.
- dma_wr_resp_valid  out  1  write response to NoC.
- dma_wr_resp_ready  in  1  response accepted.
- dma_wr_err  out  1  pulse when last marker disagrees with the beat count.
- L2_dmem_dma_wr_en  out  1  write strobe.
- L2_dmem_dma_wr_addr  out  AW  write address.
- L2_dmem_dma_wr_data  out  DW  write data.

Behaviour:
- Reset (synchronous, rst_n=0 at posedge clk):
  - State goes to IDLE; all counters and latched config are cleared.
  - All outputs are 0 while in reset and on the first cycle after it.
  - Reset mid-burst abandons the transfer; no response is issued.
- IDLE:
  - noc_in_dma_wr_ready=0.
  - On noc_cmd_dma_wr_req: assert gnt combinationally in the same cycle and latch all n_cfg_* inputs.
  - Clear pp_cnt (12b) and beat_cnt, then go to PINGPONG_CHECK.
- PINGPONG_CHECK:
  - Done condition: pingpong_en=1 and pp_cnt[11:1]==pingpong_num, or pingpong_en=0 and pp_cnt==1. Then pulse d_w_transaction_done and go to IDLE.
  - Otherwise, if pp_cnt[0]=0 and pingpong_state[0]: load addr-gen with base[0] and go to PING_WR.
  - Otherwise, if pp_cnt[0]=1 and pingpong_state[1]: load addr-gen with base[1] and go to PONG_WR.
  - Otherwise stall.
- PING_WR / PONG_WR:
  - ready=1.
  - On valid&ready, in the same cycle (zero latency): wr_en=1, wr_addr=addr_gen current address, wr_data=in_data; addr-gen advances.
  - Final beat is beat_cnt==lenth (ping or pong as selected).
  - On the final beat: clear beat_cnt, pp_cnt+=1, go to WR_RESP.
  - Otherwise beat_cnt+=1.
  - Error: in_last=1 on a non-final beat, or in_last=0 on the final beat, pulses dma_wr_err. The beat is still written and termination is by count only.
- WR_RESP:
  - ready=0; dma_wr_resp_valid=1, held until dma_wr_resp_ready.
  - On handshake: pingpong_wr_done=pingpong_en (one pulse), then go to PINGPONG_CHECK.
- Address generator, per accepted beat:
  - Find the lowest level i with cnt[i]!=loop_lenth[i]. Increment cnt[i], clear cnt[0..i-1], addr+=gap[i].
  - If all levels are saturated, clear all counters and addr+=gap[3].
  - All arithmetic is mod 2^AW (wrap, no error).
- A new request while not in IDLE is ignored (gnt=0).
- lenth=0 means a 1-beat burst.

Decomposition:
- Package dnoc_dma_pkg holds:
  - state enum (IDLE, PINGPONG_CHECK, PING_WR, PONG_WR, WR_RESP);
  - AW/DW localparams;
  - loop cfg typedef (logic [3:0][AW-1:0]).
- One sub-module, dma_wr_addr_gen:
  - inputs: clk, rst_n, init_en, init_addr, cfg_lenth, cfg_gap, adv;
  - output: addr (current, registered).
  - init_en loads init_addr and clears the counters on the next edge; addr is valid for the first beat.

Test Plan:
- pingpong_en=0, ping_lenth=3, base0=0x100, loop_lenth={0,0,0,3}, gap0=1, 4 beats with last on beat 4 -> writes 0x100..0x103, one resp, transaction_done, no err.
- pingpong_en=1, num=2, ping/pong lenth=1, base={0x200,0x000}, both buffers free -> writes 0x000,0x001,0x200,0x201,0x000,0x001,0x200,0x201; 4 pingpong_wr_done pulses; done after the 4th resp.
- Address loops: lenth0=1, gap0=1, lenth1=2, gap1=0x10, base 0 -> addrs 0,1,0x11,0x12,0x22,0x23.
- Backpressure: pingpong_state=0 for 10 cycles in PINGPONG_CHECK -> no ready, no writes; proceeds the cycle after the bit sets. Resp_ready held low for 5 cycles -> valid held stable.
- Error: last asserted on beat 2 of a 4-beat burst -> dma_wr_err pulse at beat 2; all 4 beats written.
- rst_n=0 mid-PING_WR -> next cycle all outputs 0, IDLE; a fresh command completes normally.

Source files
------------

// File: rtl/dnoc_dma_pkg.sv
// Shared definitions for the NoC-to-L2 DMA write engine.
//   DW / AW / PPW : data beat width, L2 dmem word address width, ping/pong pair-count width
//   dma_wr_state_e: write-engine FSM states
//   loop_cfg_t    : four per-level loop fields (length-minus-1 or gap), level 0 in [0]
package dnoc_dma_pkg;

  localparam int DW  = 256;
  localparam int AW  = 13;
  localparam int PPW = 11;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PINGPONG_CHECK = 3'd1,
    PING_WR        = 3'd2,
    PONG_WR        = 3'd3,
    WR_RESP        = 3'd4
  } dma_wr_state_e;

  typedef logic [3:0][AW-1:0] loop_cfg_t;

endpackage

// File: rtl/dma_wr_addr_gen.sv
// 4-level loop address generator for the DMA write engine.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   init_en     : load init_addr and clear all loop counters on the next edge
//   init_addr   : burst base address
//   cfg_lenth   : per-level iteration count minus 1
//   cfg_gap     : per-level address increment
//   adv         : one beat was written at addr; step to the next address
//   addr        : current (registered) write address
module dma_wr_addr_gen
  import dnoc_dma_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_en,
  input  logic [AW-1:0] init_addr,
  input  loop_cfg_t     cfg_lenth,
  input  loop_cfg_t     cfg_gap,
  input  logic          adv,
  output logic [AW-1:0] addr
);

  loop_cfg_t     cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;

  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (init_en) begin
      cnt_d  = '0;
      addr_d = init_addr;
    end else if (adv) begin
      // Fully saturated nest: wrap every counter and step by the outermost gap.
      cnt_d  = '0;
      addr_d = addr_q + cfg_gap[3];
      // Scan from the outermost level inwards so the lowest non-saturated
      // level is the last one to write the result.
      for (int i = 3; i >= 0; i--) begin
        if (cnt_q[i] != cfg_lenth[i]) begin
          for (int j = 0; j < 4; j++) begin
            cnt_d[j] = (j < i) ? '0 : cnt_q[j];
          end
          cnt_d[i] = cnt_q[i] + AW'(1);
          addr_d   = addr_q + cfg_gap[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/dnoc_itf_dma_wr.sv
// NoC-to-L2 DMA write engine. Accepts a write command, receives DW-bit beats
// from the NoC, writes them to L2 dmem through a 4-level loop address
// generator (optionally alternating ping/pong buffers gated by the consumer's
// buffer-free flags) and returns one write response per burst.
// Ports:
//   n_cfg_d_w_*            : command configuration, latched on grant
//   noc_cmd_dma_wr_req/gnt : command request / one-cycle combinational accept
//   pingpong_state         : [0]=ping buffer free, [1]=pong buffer free
//   pingpong_wr_done       : pulse per completed buffer (ping/pong mode only)
//   d_w_transaction_done   : pulse when the whole command has finished
//   noc_in_dma_wr_*        : inbound beat stream (data/valid/last/ready)
//   dma_wr_resp_valid/ready: per-burst write response
//   dma_wr_err             : pulse when the last marker disagrees with the beat count
//   L2_dmem_dma_wr_*       : L2 write strobe, address, data
//   dbg_state              : current FSM state
//
// Handshakes: a beat transfers in a cycle where valid and ready are both high;
// the sender holds data/last stable while valid is high and ready is low. The
// response likewise stays valid until the cycle in which ready is seen high.
module dnoc_itf_dma_wr
  import dnoc_dma_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0][AW-1:0]  n_cfg_d_w_ram_base_addr,
  input  logic [AW-1:0]       n_cfg_d_w_ping_lenth,
  input  logic [AW-1:0]       n_cfg_d_w_pong_lenth,
  input  logic                n_cfg_d_w_pingpong_en,
  input  logic [PPW-1:0]      n_cfg_d_w_pingpong_num,
  input  loop_cfg_t           n_cfg_d_w_loop_lenth,
  input  loop_cfg_t           n_cfg_d_w_loop_gap,
  input  logic                noc_cmd_dma_wr_req,
  output logic                noc_cmd_dma_wr_gnt,
  input  logic [1:0]          pingpong_state,
  output logic                pingpong_wr_done,
  output logic                d_w_transaction_done,
  input  logic [DW-1:0]       noc_in_dma_wr_data,
  input  logic                noc_in_dma_wr_valid,
  input  logic                noc_in_dma_wr_last,
  output logic                noc_in_dma_wr_ready,
  output logic                dma_wr_resp_valid,
  input  logic                dma_wr_resp_ready,
  output logic                dma_wr_err,
  output logic                L2_dmem_dma_wr_en,
  output logic [AW-1:0]       L2_dmem_dma_wr_addr,
  output logic [DW-1:0]       L2_dmem_dma_wr_data,
  output dma_wr_state_e       dbg_state
);

  dma_wr_state_e      state_q, state_d;
  logic [PPW:0]       pp_cnt_q, pp_cnt_d;
  logic [AW-1:0]      beat_cnt_q, beat_cnt_d;
  // Low for the cycle right after reset so every output stays quiet then.
  logic               active_q;

  logic [1:0][AW-1:0] base_q;
  logic [AW-1:0]      ping_len_q, pong_len_q;
  logic               pp_en_q;
  logic [PPW-1:0]     pp_num_q;
  loop_cfg_t          loop_len_q, loop_gap_q;

  logic               cfg_load;
  logic               ag_init, ag_adv;
  logic [AW-1:0]      ag_init_addr, ag_addr;
  logic               final_beat;
  logic               out_en;

  logic gnt_c, ready_c, resp_valid_c, pp_done_c, tdone_c, err_c, wr_en_c;

  dma_wr_addr_gen u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_en   (ag_init),
    .init_addr (ag_init_addr),
    .cfg_lenth (loop_len_q),
    .cfg_gap   (loop_gap_q),
    .adv       (ag_adv),
    .addr      (ag_addr)
  );

  assign final_beat = (state_q == PONG_WR) ? (beat_cnt_q == pong_len_q)
                                           : (beat_cnt_q == ping_len_q);

  always_comb begin
    state_d      = state_q;
    pp_cnt_d     = pp_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    cfg_load     = 1'b0;
    ag_init      = 1'b0;
    ag_init_addr = '0;
    ag_adv       = 1'b0;
    gnt_c        = 1'b0;
    ready_c      = 1'b0;
    resp_valid_c = 1'b0;
    pp_done_c    = 1'b0;
    tdone_c      = 1'b0;
    err_c        = 1'b0;
    wr_en_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (noc_cmd_dma_wr_req && active_q) begin
          gnt_c      = 1'b1;
          cfg_load   = 1'b1;
          pp_cnt_d   = '0;
          beat_cnt_d = '0;
          state_d    = PINGPONG_CHECK;
        end
      end
      PINGPONG_CHECK: begin
        // pp_cnt counts buffers; its upper bits count ping+pong pairs.
        if ((pp_en_q && (pp_cnt_q[PPW:1] == pp_num_q)) ||
            (!pp_en_q && (pp_cnt_q == (PPW+1)'(1)))) begin
          tdone_c = 1'b1;
          state_d = IDLE;
        end else if (!pp_cnt_q[0] && pingpong_state[0]) begin
          ag_init      = 1'b1;
          ag_init_addr = base_q[0];
          state_d      = PING_WR;
        end else if (pp_cnt_q[0] && pingpong_state[1]) begin
          ag_init      = 1'b1;
          ag_init_addr = base_q[1];
          state_d      = PONG_WR;
        end
      end
      PING_WR, PONG_WR: begin
        ready_c = 1'b1;
        if (noc_in_dma_wr_valid) begin
          wr_en_c = 1'b1;
          ag_adv  = 1'b1;
          // The beat is always written; the burst ends on the count alone.
          err_c   = noc_in_dma_wr_last ^ final_beat;
          if (final_beat) begin
            beat_cnt_d = '0;
            pp_cnt_d   = pp_cnt_q + (PPW+1)'(1);
            state_d    = WR_RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + AW'(1);
          end
        end
      end
      WR_RESP: begin
        resp_valid_c = 1'b1;
        if (dma_wr_resp_ready) begin
          pp_done_c = pp_en_q;
          state_d   = PINGPONG_CHECK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pp_cnt_q   <= '0;
      beat_cnt_q <= '0;
      active_q   <= 1'b0;
      base_q     <= '0;
      ping_len_q <= '0;
      pong_len_q <= '0;
      pp_en_q    <= 1'b0;
      pp_num_q   <= '0;
      loop_len_q <= '0;
      loop_gap_q <= '0;
    end else begin
      state_q    <= state_d;
      pp_cnt_q   <= pp_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      active_q   <= 1'b1;
      if (cfg_load) begin
        base_q     <= n_cfg_d_w_ram_base_addr;
        ping_len_q <= n_cfg_d_w_ping_lenth;
        pong_len_q <= n_cfg_d_w_pong_lenth;
        pp_en_q    <= n_cfg_d_w_pingpong_en;
        pp_num_q   <= n_cfg_d_w_pingpong_num;
        loop_len_q <= n_cfg_d_w_loop_lenth;
        loop_gap_q <= n_cfg_d_w_loop_gap;
      end
    end
  end

  // Outputs are forced low while reset is asserted (before the state register
  // has been cleared) and on the first cycle after it.
  assign out_en = rst_n & active_q;

  always_comb begin
    noc_cmd_dma_wr_gnt   = gnt_c & out_en;
    noc_in_dma_wr_ready  = ready_c & out_en;
    dma_wr_resp_valid    = resp_valid_c & out_en;
    pingpong_wr_done     = pp_done_c & out_en;
    d_w_transaction_done = tdone_c & out_en;
    dma_wr_err           = err_c & out_en;
    L2_dmem_dma_wr_en    = wr_en_c & out_en;
    L2_dmem_dma_wr_addr  = (wr_en_c & out_en) ? ag_addr : '0;
    L2_dmem_dma_wr_data  = (wr_en_c & out_en) ? noc_in_dma_wr_data : '0;
    dbg_state            = state_q;
  end

endmodule
